// File: rtl/nec_ir_rx.sv
// nec_ir_rx: NEC infrared frame/repeat decoder with tolerance-checked timing, timeouts and error reporting
module nec_ir_rx #(
  parameter int UNIT_TICKS = 1125,
  parameter int TOL_TICKS = 280,
  parameter bit IR_ACTIVE_LOW = 1,
  parameter bit CHECK_ADDR_INV = 0,
  parameter bit CHECK_CMD_INV = 1,
  parameter int REP_WINDOW_U = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IR,
  output logic [31:0] data,
  output logic        frame_valid,
  output logic        rep_valid,
  output logic [7:0]  rep_cnt,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [2:0]  state
);
  localparam int RW = $clog2(20 * UNIT_TICKS + 1);
  localparam int WMAX = REP_WINDOW_U * UNIT_TICKS;
  localparam int WW = $clog2(WMAX + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, LEAD_MARK = 3'd1, LEAD_SPACE = 3'd2, BIT_MARK = 3'd3, BIT_SPACE = 3'd4, STOP_MARK = 3'd5} st_t;
  st_t st, nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic m, m_q, chg, rep, ok, inv_ok;
  logic [RW-1:0] run;
  logic [WW-1:0] win;
  logic [4:0] idx;
  logic [31:0] sr, len, lim;
  function automatic logic fits(input logic [31:0] l, input int n);
    logic [31:0] c;
    c = 32'(n * UNIT_TICKS);
    return (l + 32'(TOL_TICKS) >= c) && (l <= c + 32'(TOL_TICKS));
  endfunction
  assign m = sync[SYNC_STAGES-1] ^ IR_ACTIVE_LOW;
  assign chg = m != m_q;
  assign len = 32'(run);
  assign busy = st != IDLE;
  assign state = st;
  assign inv_ok = (!CHECK_ADDR_INV || sr[15:8] == ~sr[7:0]) && (!CHECK_CMD_INV || sr[31:24] == ~sr[23:16]);
  always_comb begin
    nxt = IDLE;
    ok = 1'b1;
    lim = 32'(UNIT_TICKS * (st == LEAD_MARK ? 16 : st == LEAD_SPACE ? 8 : st == BIT_SPACE ? 3 : 1) + TOL_TICKS);
    case (st)
      IDLE:       nxt = m ? LEAD_MARK : IDLE;
      LEAD_MARK:  begin ok = fits(len, 16); nxt = LEAD_SPACE; end
      LEAD_SPACE: begin ok = fits(len, 8) || fits(len, 4); nxt = fits(len, 8) ? BIT_MARK : STOP_MARK; end
      BIT_MARK:   begin ok = fits(len, 1); nxt = BIT_SPACE; end
      BIT_SPACE:  begin ok = fits(len, 1) || fits(len, 3); nxt = idx == 5'd31 ? STOP_MARK : BIT_MARK; end
      default:    ok = fits(len, 1);
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {SYNC_STAGES{IR_ACTIVE_LOW}};
      m_q <= 1'b0;
      run <= '0;
      win <= '0;
      st <= IDLE;
      idx <= '0;
      sr <= '0;
      rep <= 1'b0;
      data <= '0;
      rep_cnt <= '0;
      err_code <= '0;
      frame_valid <= 1'b0;
      rep_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], IR};
      m_q <= m;
      run <= chg ? RW'(1) : (&run ? run : run + RW'(1));
      win <= (win != '0) ? win - WW'(1) : win;
      frame_valid <= 1'b0;
      rep_valid <= 1'b0;
      err <= 1'b0;
      // the level has outlived its longest legal length: give up without waiting for the edge
      if (st != IDLE && !chg && len > lim) begin
        st <= IDLE;
        err <= 1'b1;
        err_code <= 2'd1;
      end else if (chg) begin
        if (!ok) begin
          st <= IDLE;
          err <= 1'b1;
          err_code <= 2'd0;
        end else begin
          st <= nxt;
          if (st == LEAD_SPACE) begin
            idx <= '0;
            rep <= !fits(len, 8);
          end
          if (st == BIT_SPACE) begin
            sr[idx] <= fits(len, 3);
            idx <= idx + 5'd1;
          end
          if (st == STOP_MARK) begin
            if (!rep && inv_ok) begin
              data <= sr;
              frame_valid <= 1'b1;
              rep_cnt <= '0;
              win <= WW'(WMAX);
            end else if (rep && win != '0) begin
              rep_valid <= 1'b1;
              rep_cnt <= &rep_cnt ? rep_cnt : rep_cnt + 8'd1;
              win <= WW'(WMAX);
            end else begin
              err <= 1'b1;
              err_code <= rep ? 2'd3 : 2'd2;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_nec_ir_rx.sv
// tb_nec_ir_rx: scoreboard bench for nec_ir_rx with 10-tick units and 2-tick tolerance
module tb_nec_ir_rx;
  logic clk = 1'b0, reset = 1'b1, IR = 1'b1;
  logic [31:0] data;
  logic frame_valid, rep_valid, err, busy;
  logic [7:0] rep_cnt;
  logic [1:0] err_code;
  logic [2:0] state;
  typedef struct { logic [1:0] k; logic [7:0] c; logic [31:0] d; } ev_t;
  ev_t q[$];
  ev_t e;
  logic [31:0] cur_d = '0;
  logic [7:0] cur_r = '0;
  int n_vec = 0, n_bad = 0;
  nec_ir_rx #(.UNIT_TICKS(10), .TOL_TICKS(2)) dut (
    .clk(clk), .reset(reset), .IR(IR), .data(data), .frame_valid(frame_valid),
    .rep_valid(rep_valid), .rep_cnt(rep_cnt), .err(err), .err_code(err_code),
    .busy(busy), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic want(input logic [1:0] k, input logic [7:0] c);
    q.push_back('{k: k, c: c, d: cur_d});
  endtask
  task automatic lvl(input logic mk, input int n);
    IR = ~mk;
    repeat (n) @(negedge clk);
  endtask
  task automatic frame(input logic [31:0] b, input int lead, input int bad_i, input int bad_len, input int gap);
    lvl(1'b1, lead);
    if (lead < 158 || lead > 162) begin
      lvl(1'b0, gap);
      return;
    end
    lvl(1'b0, 80);
    for (int i = 0; i < 32; i++) begin
      lvl(1'b1, 10);
      if (i == bad_i) begin
        lvl(1'b0, bad_len);
        lvl(1'b1, 10);
        lvl(1'b0, gap);
        return;
      end
      lvl(1'b0, b[i] ? 30 : 10);
    end
    lvl(1'b1, 10);
    lvl(1'b0, gap);
  endtask
  task automatic rpt(input int gap);
    lvl(1'b1, 160);
    lvl(1'b0, 40);
    lvl(1'b1, 10);
    lvl(1'b0, gap);
  endtask
  task automatic good(input logic [31:0] b, input int lead, input int gap);
    cur_d = b;
    cur_r = 8'd0;
    want(2'd0, 8'd0);
    frame(b, lead, -1, 0, gap);
  endtask
  always @(negedge clk) begin
    if (!reset && (frame_valid || rep_valid || err)) begin
      if (q.size() == 0) chk("spurious", 32'({frame_valid, rep_valid, err}), 32'd0);
      else begin
        e = q.pop_front();
        chk("kind", frame_valid ? 32'd0 : rep_valid ? 32'd1 : 32'd2, 32'(e.k));
        chk("code", err ? 32'(err_code) : 32'(rep_cnt), 32'(e.c));
        chk("data", data, e.d);
        chk("excl", 32'(frame_valid) + 32'(rep_valid) + 32'(err), 32'd1);
        chk("idle", 32'({busy, state}), 32'd0);
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_data", data, 32'd0);
    chk("rst_state", 32'({busy, state, rep_cnt, err_code, frame_valid, rep_valid, err}), 32'd0);
    good(32'hF708FB04, 160, 500);
    cur_r = 8'd1;
    want(2'd1, cur_r);
    rpt(2100);
    want(2'd2, 8'd3);
    rpt(300);
    chk("rep_hold", 32'(rep_cnt), 32'd1);
    want(2'd2, 8'd2);
    frame(32'hF608FB04, 160, -1, 0, 200);
    want(2'd2, 8'd0);
    frame(32'hA55A1234, 160, 5, 21, 200);
    good(32'hA55A1234, 160, 300);
    cur_r = 8'd1;
    want(2'd1, cur_r);
    rpt(200);
    want(2'd2, 8'd0);
    frame(32'hA55A1234, 150, -1, 0, 200);
    want(2'd2, 8'd1);
    lvl(1'b1, 160);
    lvl(1'b0, 80);
    lvl(1'b1, 200);
    lvl(1'b0, 200);
    lvl(1'b1, 160);
    lvl(1'b0, 80);
    for (int i = 0; i < 17; i++) begin
      lvl(1'b1, 10);
      lvl(1'b0, i[0] ? 30 : 10);
    end
    lvl(1'b1, 5);
    reset = 1'b1;
    IR = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cur_d = '0;
    cur_r = '0;
    @(negedge clk);
    chk("mid_rst_data", data, 32'd0);
    chk("mid_rst_state", 32'({busy, state, rep_cnt, err_code, frame_valid, rep_valid, err}), 32'd0);
    lvl(1'b0, 100);
    good(32'hE11E00FF, 158, 200);
    good(32'h7F80AA55, 162, 200);
    want(2'd2, 8'd0);
    frame(32'h7F80AA55, 157, -1, 0, 200);
    want(2'd2, 8'd0);
    frame(32'h7F80AA55, 163, -1, 0, 200);
    repeat (50) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    chk("final_data", data, 32'h7F80AA55);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/nec_ir_rx.md
NEC_IR_RX -- requirements
Module: nec_ir_rx

Interface
REQ-001 Parameter UNIT_TICKS, default 1125, clk cycles per 562.5 us NEC base unit U (2 MHz clk).
REQ-002 Parameter TOL_TICKS, default 280, inclusive +/- tolerance on every measured interval.
REQ-003 Parameter IR_ACTIVE_LOW, default 1, 1 = burst (mark) is IR low, idle high.
REQ-004 Parameter CHECK_ADDR_INV, default 0, 1 = require data[15:8] == ~data[7:0]; 0 = 16-bit extended address accepted.
REQ-005 Parameter CHECK_CMD_INV, default 1, 1 = require data[31:24] == ~data[23:16].
REQ-006 Parameter REP_WINDOW_U, default 200, repeat-acceptance window in units U after the last valid frame or repeat.
REQ-007 Parameter SYNC_STAGES, default 2, input synchroniser depth, >= 2.
REQ-008 clk  input  1  single clock; all state on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 IR  input  1  asynchronous demodulated IR receiver output.
REQ-011 data  output  32  last valid frame, first-received bit in data[0].
REQ-012 frame_valid  output  1  one-cycle pulse, data updated this cycle.
REQ-013 rep_valid  output  1  one-cycle pulse, accepted repeat code.
REQ-014 rep_cnt  output  8  repeats since last valid frame, saturates at 255.
REQ-015 err  output  1  one-cycle pulse on any rejected sequence.
REQ-016 err_code  output  2  0 timing, 1 timeout, 2 inversion check, 3 orphan repeat; held until next err.
REQ-017 busy  output  1  high whenever state != IDLE.
REQ-018 state  output  3  FSM state, debug/LED use.

Function
REQ-019 IR passes through SYNC_STAGES flops, then is normalised to m (1 = mark) per IR_ACTIVE_LOW.
REQ-020 A run-length counter counts consecutive cycles of constant m, clears on each m change, saturates at all-ones; width = clog2(20*UNIT_TICKS+1).
REQ-021 Interval L matches N units iff N*UNIT_TICKS-TOL_TICKS <= L <= N*UNIT_TICKS+TOL_TICKS; L is cycles the previous level held, evaluated in the cycle m changes.
REQ-022 States: IDLE=0, LEAD_MARK=1, LEAD_SPACE=2, BIT_MARK=3, BIT_SPACE=4, STOP_MARK=5.
REQ-023 IDLE: m rising -> LEAD_MARK; space of any length legal.
REQ-024 LEAD_MARK: mark end with L matching 16 -> LEAD_SPACE; else err code 0 -> IDLE.
REQ-025 LEAD_SPACE: space end matching 8 -> BIT_MARK, bit index 0; matching 4 -> STOP_MARK with repeat flag; else code 0 -> IDLE.
REQ-026 BIT_MARK: end matching 1 -> BIT_SPACE; else code 0 -> IDLE.
REQ-027 BIT_SPACE: end matching 1 shifts 0, matching 3 shifts 1 into shift-register bit[index]; index 31 -> STOP_MARK, else BIT_MARK; other L -> code 0 -> IDLE.
REQ-028 STOP_MARK: end matching 1 completes frame (REQ-030) or repeat (REQ-031); else code 0 -> IDLE.
REQ-029 Timeout: in any non-IDLE state, run length exceeding the state's longest legal interval + TOL_TICKS (16U, 8U, 1U, 3U, 1U) -> err code 1 -> IDLE immediately, without waiting for an edge.
REQ-030 Frame end: enabled inversion checks pass -> data loaded, frame_valid, rep_cnt cleared, window restarted; fail -> code 2, data unchanged.
REQ-031 Repeat end: window open -> rep_valid, rep_cnt+1 (saturating), window restarted; closed -> code 3, rep_cnt unchanged.
REQ-032 Window counter counts clk cycles up to REP_WINDOW_U*UNIT_TICKS then closes; closed after reset.
REQ-033 frame_valid/rep_valid/err are registered, asserted exactly one cycle after the final m change, never simultaneously; FSM returns to IDLE in that same cycle.
REQ-034 Internal shift register never drives data directly; data changes only with frame_valid.

Reset
REQ-035 reset forces IDLE, run counter 0, window closed, data 0, rep_cnt 0, err_code 0, all pulses 0, synchroniser flops to idle level.
REQ-036 reset asserted mid-frame abandons the frame with no err pulse; a mark in progress at release is measured from release.

Verification (UNIT_TICKS=10, TOL_TICKS=2, defaults otherwise)
REQ-037 Frame addr 0x04, cmd 0x08 (bits 0x F708FB04) nominal timing -> frame_valid once, data=0xF708FB04, rep_cnt=0, err never.
REQ-038 Same frame then repeat (160 mark, 40 space, 10 mark) 500 cycles later -> rep_valid, rep_cnt=1; repeat 2100 cycles after that -> err, err_code=3.
REQ-039 Frame with cmd byte 0x08, inverse 0xF6 -> err, err_code=2, data keeps prior value.
REQ-040 Bit space 21 cycles (outside 1U and 3U) -> err code 0, next well-formed frame accepted; leader mark 150 -> err code 0.
REQ-041 Mark held 200 cycles in BIT_MARK -> err code 1 at run length 13, busy drops next cycle.
REQ-042 reset pulsed at bit 17 -> all outputs zero, no err; following frame decodes; boundary lengths 158/162 accepted, 157/163 rejected.
